// File: rtl/vc_flit_tx.sv
// vc_flit_tx: packs a request plus payload words into head/body/tail flits for one
// virtual-channel buffer, through a single registered output stage.
//
// Flit layout (fdata_o):
//   [33:32] type: 00 head, 01 body, 11 tail
//   head: [31:30]=00, [29:26]=dest_x, [25:22]=dest_y, [21:14]=len, [13:0]=0
//   body/tail: [31:0] payload word (a len=0 tail carries zero)
//
// FSM state names the flit held in the output register:
//   StIdle - register empty, a request can be accepted
//   StHead - head flit held; payload words may stream in behind it
//   StBody - a body flit is held (or the register drained while waiting for payload)
//   StTail - tail flit held; its transfer completes the packet
// Payload is taken while the head or body flits drain, so a packet streams at one
// flit per cycle when ready_i stays high.
module vc_flit_tx (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_dest_x_i,
  input  logic [3:0]  req_dest_y_i,
  input  logic [7:0]  req_len_i,
  input  logic [1:0]  req_vc_i,
  input  logic        pld_valid_i,
  output logic        pld_ready_o,
  input  logic [31:0] pld_data_i,
  output logic [33:0] fdata_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [1:0]  vc_id_o,
  output logic        busy_o,
  output logic        err_dest_o,
  output logic [15:0] pkt_cnt_o
);

  localparam logic [1:0] TypeHead = 2'b00;
  localparam logic [1:0] TypeBody = 2'b01;
  localparam logic [1:0] TypeTail = 2'b11;

  typedef enum logic [1:0] {StIdle, StHead, StBody, StTail} state_e;

  state_e      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [33:0] fdata_q, fdata_d;
  logic        valid_q, valid_d;
  logic [1:0]  vc_q, vc_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic can_load;
  logic accept;
  logic dest_zero;
  logic pld_ready;
  logic pld_fire;
  logic last_word;

  // Handshake qualifiers shared by the next-state logic and the ports
  always_comb begin
    can_load  = !valid_q || ready_i;
    accept    = req_valid_i && (state_q == StIdle);
    dest_zero = (req_dest_x_i == 4'd0) && (req_dest_y_i == 4'd0);
    // rem_q is zero only for a len=0 packet, which never handshakes payload
    pld_ready = ((state_q == StHead) || (state_q == StBody)) && (rem_q != 8'd0) && can_load;
    pld_fire  = pld_valid_i && pld_ready;
    last_word = (rem_q == 8'd1);
  end

  // Next-state for the FSM, the output register, the word counter and the packet count
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fdata_d = fdata_q;
    valid_d = valid_q;
    vc_d    = vc_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (dest_zero) begin
            // Zero destination would never be consumed downstream: drop and flag it
            err_d = 1'b1;
          end else begin
            fdata_d = {TypeHead, 2'b00, req_dest_x_i, req_dest_y_i, req_len_i, 14'd0};
            valid_d = 1'b1;
            vc_d    = req_vc_i;
            rem_d   = req_len_i;
            state_d = StHead;
          end
        end
      end

      StHead, StBody: begin
        if (can_load) begin
          if (rem_q == 8'd0) begin
            // len=0: the tail follows the head directly with a zero payload
            fdata_d = {TypeTail, 32'd0};
            valid_d = 1'b1;
            state_d = StTail;
          end else if (pld_fire) begin
            fdata_d = {(last_word ? TypeTail : TypeBody), pld_data_i};
            valid_d = 1'b1;
            rem_d   = rem_q - 8'd1;
            state_d = last_word ? StTail : StBody;
          end else begin
            // Register drains with no payload ready: bubble until the next word
            valid_d = 1'b0;
            state_d = StBody;
          end
        end
      end

      StTail: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 16'd1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // All state registers; asynchronous reset abandons any packet in flight
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= StIdle;
      rem_q   <= 8'd0;
      fdata_q <= 34'd0;
      valid_q <= 1'b0;
      vc_q    <= 2'd0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      fdata_q <= fdata_d;
      valid_q <= valid_d;
      vc_q    <= vc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Port drive: everything except the two ready signals comes straight from flops
  always_comb begin
    req_ready_o = (state_q == StIdle);
    pld_ready_o = pld_ready;
    fdata_o     = fdata_q;
    valid_o     = valid_q;
    vc_id_o     = vc_q;
    busy_o      = (state_q != StIdle);
    err_dest_o  = err_q;
    pkt_cnt_o   = cnt_q;
  end

endmodule

// File: tb/tb_vc_flit_tx.sv
// Directed bench for vc_flit_tx: one task per scenario, inline comparisons.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_vc_flit_tx;

  logic        clk;
  logic        arst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_dest_x_i;
  logic [3:0]  req_dest_y_i;
  logic [7:0]  req_len_i;
  logic [1:0]  req_vc_i;
  logic        pld_valid_i;
  logic        pld_ready_o;
  logic [31:0] pld_data_i;
  logic [33:0] fdata_o;
  logic        valid_o;
  logic        ready_i;
  logic [1:0]  vc_id_o;
  logic        busy_o;
  logic        err_dest_o;
  logic [15:0] pkt_cnt_o;

  int checks;
  int failures;
  logic [15:0] exp_cnt;

  vc_flit_tx dut (
    .clk          (clk),
    .arst         (arst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_dest_x_i (req_dest_x_i),
    .req_dest_y_i (req_dest_y_i),
    .req_len_i    (req_len_i),
    .req_vc_i     (req_vc_i),
    .pld_valid_i  (pld_valid_i),
    .pld_ready_o  (pld_ready_o),
    .pld_data_i   (pld_data_i),
    .fdata_o      (fdata_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .vc_id_o      (vc_id_o),
    .busy_o       (busy_o),
    .err_dest_o   (err_dest_o),
    .pkt_cnt_o    (pkt_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len,
                           input logic [1:0] vc);
    req_valid_i  = 1'b1;
    req_dest_x_i = dx;
    req_dest_y_i = dy;
    req_len_i    = len;
    req_vc_i     = vc;
  endtask

  task automatic test_reset;
    arst = 1'b0;
    req_valid_i = 1'b0; req_dest_x_i = 4'd0; req_dest_y_i = 4'd0; req_len_i = 8'd0;
    req_vc_i = 2'd0; pld_valid_i = 1'b0; pld_data_i = 32'd0; ready_i = 1'b1;
    tick; tick;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
    checks++; if (fdata_o !== 34'd0) begin failures++; $display("FAIL rst_fdata got=%h exp=0", fdata_o); end
    checks++; if (vc_id_o !== 2'd0) begin failures++; $display("FAIL rst_vc got=%h exp=0", vc_id_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (err_dest_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_dest_o); end
    checks++; if (pld_ready_o !== 1'b0) begin failures++; $display("FAIL rst_pld_ready got=%b exp=0", pld_ready_o); end
    checks++; if (pkt_cnt_o !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%h exp=0", pkt_cnt_o); end
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready_o); end
    @(negedge clk);
    arst = 1'b1;
    tick;
    exp_cnt = 16'd0;
  endtask

  // dest=(1,2) len=0 vc=1: head = (1<<26)|(2<<22) = 0x0480_0000
  task automatic test_len0;
    drive_req(4'd1, 4'd2, 8'd0, 2'd1);
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL l0_req_ready got=%b exp=1", req_ready_o); end
    tick;
    req_valid_i = 1'b0;
    checks++; if ({valid_o, fdata_o} !== {1'b1, 34'h0_0480_0000}) begin failures++; $display("FAIL l0_head got=%b/%h exp=1/004800000", valid_o, fdata_o); end
    checks++; if (vc_id_o !== 2'd1) begin failures++; $display("FAIL l0_head_vc got=%h exp=1", vc_id_o); end
    checks++; if (busy_o !== 1'b1 || req_ready_o !== 1'b0) begin failures++; $display("FAIL l0_busy got=%b/%b exp=1/0", busy_o, req_ready_o); end
    checks++; if (pld_ready_o !== 1'b0) begin failures++; $display("FAIL l0_pld_ready got=%b exp=0", pld_ready_o); end
    tick;
    checks++; if ({valid_o, fdata_o} !== {1'b1, 34'h3_0000_0000}) begin failures++; $display("FAIL l0_tail got=%b/%h exp=1/300000000", valid_o, fdata_o); end
    checks++; if (vc_id_o !== 2'd1) begin failures++; $display("FAIL l0_tail_vc got=%h exp=1", vc_id_o); end
    tick;
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL l0_done got=%b/%b exp=0/0", valid_o, busy_o); end
    checks++; if (pkt_cnt_o !== exp_cnt) begin failures++; $display("FAIL l0_cnt got=%h exp=%h", pkt_cnt_o, exp_cnt); end
  endtask

  // dest=(3,4) len=3 vc=2: head = 0x0C00_0000|0x0100_0000|(3<<14) = 0x0D00_C000
  task automatic test_len3;
    logic [31:0] words [3];
    words[0] = 32'hAAAA_0001; words[1] = 32'hBBBB_0002; words[2] = 32'hCCCC_0003;
    drive_req(4'd3, 4'd4, 8'd3, 2'd2);
    tick;
    req_valid_i = 1'b0;
    checks++; if ({valid_o, fdata_o} !== {1'b1, 34'h0_0D00_C000}) begin failures++; $display("FAIL l3_head got=%b/%h exp=1/00d00c000", valid_o, fdata_o); end
    for (int i = 0; i < 3; i++) begin
      pld_valid_i = 1'b1;
      pld_data_i  = words[i];
      checks++; if (pld_ready_o !== 1'b1) begin failures++; $display("FAIL l3_pld_ready%0d got=%b exp=1", i, pld_ready_o); end
      tick;
      checks++; if ({valid_o, fdata_o} !== {1'b1, (i == 2) ? 2'b11 : 2'b01, words[i]}) begin failures++; $display("FAIL l3_flit%0d got=%b/%h exp=1/%h", i, valid_o, fdata_o, {(i == 2) ? 2'b11 : 2'b01, words[i]}); end
      checks++; if (vc_id_o !== 2'd2) begin failures++; $display("FAIL l3_vc%0d got=%h exp=2", i, vc_id_o); end
    end
    pld_valid_i = 1'b0;
    checks++; if (pld_ready_o !== 1'b0) begin failures++; $display("FAIL l3_pld_tail got=%b exp=0", pld_ready_o); end
    tick;
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (valid_o !== 1'b0 || pkt_cnt_o !== exp_cnt) begin failures++; $display("FAIL l3_done got=%b/%h exp=0/%h", valid_o, pkt_cnt_o, exp_cnt); end
  endtask

  // dest=(5,6) len=1 vc=3: head = 0x1400_0000|0x0180_0000|(1<<14) = 0x1580_4000
  task automatic test_stall;
    ready_i = 1'b0;
    drive_req(4'd5, 4'd6, 8'd1, 2'd3);
    tick;
    req_valid_i = 1'b0;
    pld_valid_i = 1'b1;
    pld_data_i  = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({valid_o, fdata_o, vc_id_o} !== {1'b1, 34'h0_1580_4000, 2'd3}) begin failures++; $display("FAIL stall_hold%0d got=%b/%h/%h exp=1/015804000/3", i, valid_o, fdata_o, vc_id_o); end
      checks++; if (pld_ready_o !== 1'b0) begin failures++; $display("FAIL stall_pld%0d got=%b exp=0", i, pld_ready_o); end
      tick;
    end
    ready_i = 1'b1;
    #1;
    checks++; if (pld_ready_o !== 1'b1) begin failures++; $display("FAIL stall_resume_pld got=%b exp=1", pld_ready_o); end
    tick;
    pld_valid_i = 1'b0;
    checks++; if ({valid_o, fdata_o} !== {1'b1, 34'h3_1234_5678}) begin failures++; $display("FAIL stall_tail got=%b/%h exp=1/312345678", valid_o, fdata_o); end
    tick;
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (pkt_cnt_o !== exp_cnt) begin failures++; $display("FAIL stall_cnt got=%h exp=%h", pkt_cnt_o, exp_cnt); end
  endtask

  task automatic test_bad_dest;
    drive_req(4'd0, 4'd0, 8'd4, 2'd1);
    tick;
    req_valid_i = 1'b0;
    checks++; if (err_dest_o !== 1'b1) begin failures++; $display("FAIL bad_err_pulse got=%b exp=1", err_dest_o); end
    checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL bad_no_flit got=%b/%b exp=0/0", valid_o, busy_o); end
    tick;
    checks++; if (err_dest_o !== 1'b0) begin failures++; $display("FAIL bad_err_clear got=%b exp=0", err_dest_o); end
    checks++; if (valid_o !== 1'b0 || pkt_cnt_o !== exp_cnt) begin failures++; $display("FAIL bad_cnt got=%b/%h exp=0/%h", valid_o, pkt_cnt_o, exp_cnt); end
  endtask

  // dest=(7,1) len=0 vc=0 twice with req_valid held: head = 0x1C00_0000|0x0040_0000
  task automatic test_back_to_back;
    logic [5:0] exp_valid;
    exp_valid = 6'b110110;
    drive_req(4'd7, 4'd1, 8'd0, 2'd0);
    for (int i = 0; i < 6; i++) begin
      tick;
      if (i == 3) req_valid_i = 1'b0;
      checks++; if (valid_o !== exp_valid[5 - i]) begin failures++; $display("FAIL b2b_valid%0d got=%b exp=%b", i, valid_o, exp_valid[5 - i]); end
      if (i == 0 || i == 3) begin
        checks++; if (fdata_o !== 34'h0_1C40_0000) begin failures++; $display("FAIL b2b_head%0d got=%h exp=01c400000", i, fdata_o); end
      end
      if (i == 2) begin
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_bubble_ready got=%b exp=1", req_ready_o); end
      end
    end
    exp_cnt = exp_cnt + 16'd2;
    checks++; if (pkt_cnt_o !== exp_cnt) begin failures++; $display("FAIL b2b_cnt got=%h exp=%h", pkt_cnt_o, exp_cnt); end
  endtask

  // dest=(2,2) len=5, reset after 2nd body; then dest=(1,1) len=0: head 0x0440_0000
  task automatic test_mid_reset;
    drive_req(4'd2, 4'd2, 8'd5, 2'd1);
    tick;
    req_valid_i = 1'b0;
    pld_valid_i = 1'b1;
    pld_data_i  = 32'h0000_0011;
    tick;
    pld_data_i  = 32'h0000_0022;
    tick;
    pld_valid_i = 1'b0;
    checks++; if (fdata_o !== 34'h1_0000_0022) begin failures++; $display("FAIL mr_body2 got=%h exp=100000022", fdata_o); end
    arst = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0 || fdata_o !== 34'd0) begin failures++; $display("FAIL mr_async got=%b/%h exp=0/0", valid_o, fdata_o); end
    checks++; if (busy_o !== 1'b0 || pkt_cnt_o !== 16'd0) begin failures++; $display("FAIL mr_state got=%b/%h exp=0/0", busy_o, pkt_cnt_o); end
    @(negedge clk);
    arst = 1'b1;
    tick;
    exp_cnt = 16'd0;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL mr_no_tail got=%b exp=0", valid_o); end
    drive_req(4'd1, 4'd1, 8'd0, 2'd0);
    tick;
    req_valid_i = 1'b0;
    checks++; if ({valid_o, fdata_o} !== {1'b1, 34'h0_0440_0000}) begin failures++; $display("FAIL mr_fresh_head got=%b/%h exp=1/004400000", valid_o, fdata_o); end
    tick; tick;
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (pkt_cnt_o !== exp_cnt) begin failures++; $display("FAIL mr_cnt got=%h exp=%h", pkt_cnt_o, exp_cnt); end
  endtask

  // Counter is preset to 0xFFFE so the wrap is reached in a few packets
  task automatic test_wrap;
    force dut.cnt_q = 16'hFFFE;
    tick;
    release dut.cnt_q;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      drive_req(4'd0, 4'd9, 8'd0, 2'd2);
      tick;
      req_valid_i = 1'b0;
      tick; tick;
      exp_cnt = exp_cnt + 16'd1;
      checks++; if (pkt_cnt_o !== exp_cnt) begin failures++; $display("FAIL wrap_cnt%0d got=%h exp=%h", i, pkt_cnt_o, exp_cnt); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 16'd0;
    test_reset;
    test_len0;
    test_len3;
    test_stall;
    test_bad_dest;
    test_back_to_back;
    test_mid_reset;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
